regfile_wb_arbiter: RTL and testbench

//  Writer-side front end of the 4-write/8-read physical register file.
//  - Collects completed results from NSRC execution units over valid/ready.
//  - Buffers them per source and drives up to 4 write ports per cycle
//    (we/waddr/wdata 0..3), which connect directly to the register file.
//  - Sits between the execute/complete stage and the register file.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_queue.sv | 42 ++++
 rtl/regfile_wb_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file write-back arbiter and its per-source queues.
package wb_pkg;
    localparam int NPORTS    = 4;
    localparam int WB_ADDR_W = 5;
    localparam logic [WB_ADDR_W-1:0] ADDR_ZERO = '0;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] waddr;
        logic [31:0]          wdata;
    } wb_entry_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/wb_queue.sv
// Per-source result FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = $bits(wb_entry_t)
)(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wr_entry,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);
    localparam int AW = clog2(DEPTH);

    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr_reg[AW-1:0]] <= wr_entry;
    end

    // Head is read combinationally so the selector sees it in the cycle after the push.
    assign head  = mem[rd_ptr_reg[AW-1:0]];
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back front end: per-source queues, round-robin selector for 4 register-file write ports.
// Optional same-cycle bypass of empty queues is enabled by defining WB_BYPASS_EN.
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int WIDTH = WB_ADDR_W,
    parameter int NSRC  = 6,
    parameter int DEPTH = 2
)(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NSRC-1:0]         i_valid,
    output logic [NSRC-1:0]         o_ready,
    input  logic [NSRC*WIDTH-1:0]   i_waddr,
    input  logic [NSRC*32-1:0]      i_wdata,
    output logic [NPORTS-1:0]       o_we,
    output logic [NPORTS*WIDTH-1:0] o_waddr,
    output logic [NPORTS*32-1:0]    o_wdata,
    output logic                    o_busy
);
    localparam int SW = clog2(NSRC);
    localparam int CW = clog2(NPORTS) + 1;

    wb_entry_t         in_ent   [NSRC];
    wb_entry_t         head_ent [NSRC];
    wb_entry_t         cand_ent [NSRC];
    logic [NSRC-1:0]   q_full, q_empty, q_push, q_pop;
    logic [NSRC-1:0]   accept, cand_vld, chosen;
    logic              live_reg;
    logic [SW-1:0]     rr_reg, rr_next, last_src, src;
    logic [CW-1:0]     sel_cnt;
    logic              conflict;
    logic [NPORTS-1:0] port_vld;
    wb_entry_t         port_ent [NPORTS];
    logic [NPORTS-1:0] we_reg;
    wb_entry_t         out_reg  [NPORTS];

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            assign in_ent[gi] = {i_waddr[gi*WIDTH +: WIDTH], i_wdata[gi*32 +: 32]};
            assign accept[gi] = i_valid[gi] & o_ready[gi];
`ifdef WB_BYPASS_EN
            // An empty queue offers the incoming result directly; it is queued only if not taken.
            assign cand_vld[gi] = !q_empty[gi] || accept[gi];
            assign cand_ent[gi] = q_empty[gi] ? in_ent[gi] : head_ent[gi];
            assign q_push[gi]   = accept[gi] && !(chosen[gi] && q_empty[gi]);
            assign q_pop[gi]    = chosen[gi] && !q_empty[gi];
`else
            assign cand_vld[gi] = !q_empty[gi];
            assign cand_ent[gi] = head_ent[gi];
            assign q_push[gi]   = accept[gi];
            assign q_pop[gi]    = chosen[gi];
`endif
            wb_queue #(.DEPTH(DEPTH), .DW($bits(wb_entry_t))) u_queue (
                .i_clk    (i_clk),
                .i_rst_n  (i_rst_n),
                .push     (q_push[gi]),
                .pop      (q_pop[gi]),
                .wr_entry (in_ent[gi]),
                .head     (head_ent[gi]),
                .full     (q_full[gi]),
                .empty    (q_empty[gi])
            );
        end
    endgenerate

    // Scan from rr with wrap; a head whose address is already taken this cycle stays queued.
    always_comb begin
        src      = rr_reg;
        last_src = rr_reg;
        sel_cnt  = '0;
        chosen   = '0;
        port_vld = '0;
        conflict = 1'b0;
        for (int p = 0; p < NPORTS; p++) port_ent[p] = '0;
        for (int k = 0; k < NSRC; k++) begin
            conflict = 1'b0;
            for (int p = 0; p < NPORTS; p++) begin
                if (port_vld[p] && (port_ent[p].waddr == cand_ent[src].waddr)) conflict = 1'b1;
            end
            if (cand_vld[src] && !conflict && (sel_cnt != CW'(NPORTS))) begin
                chosen[src]               = 1'b1;
                port_vld[sel_cnt[CW-2:0]] = 1'b1;
                port_ent[sel_cnt[CW-2:0]] = cand_ent[src];
                sel_cnt                   = sel_cnt + CW'(1);
                last_src                  = src;
            end
            src = (src == SW'(NSRC-1)) ? '0 : src + SW'(1);
        end
    end

    assign rr_next = (|chosen) ? ((last_src == SW'(NSRC-1)) ? '0 : last_src + SW'(1)) : rr_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            live_reg <= 1'b0;
            rr_reg   <= '0;
            we_reg   <= '0;
            for (int p = 0; p < NPORTS; p++) out_reg[p] <= '0;
        end else begin
            live_reg <= 1'b1;
            rr_reg   <= rr_next;
            for (int p = 0; p < NPORTS; p++) begin
                // Address-zero entries consume a slot but never reach the register file.
                we_reg[p] <= port_vld[p] && (port_ent[p].waddr != ADDR_ZERO);
                if (port_vld[p] && (port_ent[p].waddr != ADDR_ZERO)) out_reg[p] <= port_ent[p];
            end
        end
    end

    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_port
            assign o_waddr[gi*WIDTH +: WIDTH] = out_reg[gi].waddr;
            assign o_wdata[gi*32 +: 32]       = out_reg[gi].wdata;
        end
    endgenerate

    assign o_we    = we_reg;
    assign o_ready = ~q_full & {NSRC{live_reg}};
    assign o_busy  = (~&q_empty) | (|we_reg);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; define WB_BYPASS_EN to check the one-clock-latency build.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
    localparam int WIDTH = 5;
    localparam int NSRC  = 6;
    localparam int DEPTH = 2;
`ifdef WB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic                  i_clk   = 1'b0;
    logic                  i_rst_n = 1'b1;
    logic [NSRC-1:0]       i_valid = '0;
    logic [NSRC-1:0]       o_ready;
    logic [NSRC*WIDTH-1:0] i_waddr = '0;
    logic [NSRC*32-1:0]    i_wdata = '0;
    logic [3:0]            o_we;
    logic [4*WIDTH-1:0]    o_waddr;
    logic [4*32-1:0]       o_wdata;
    logic                  o_busy;

    int vectors     = 0;
    int miscompares = 0;

    regfile_wb_arbiter #(.WIDTH(WIDTH), .NSRC(NSRC), .DEPTH(DEPTH)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_waddr (i_waddr),
        .i_wdata (i_wdata),
        .o_we    (o_we),
        .o_waddr (o_waddr),
        .o_wdata (o_wdata),
        .o_busy  (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input int s, input logic [4:0] a, input logic [31:0] d);
        i_valid[s]               = 1'b1;
        i_waddr[s*WIDTH +: WIDTH] = a;
        i_wdata[s*32 +: 32]       = d;
    endtask

    task automatic test_reset();
        #2 i_rst_n = 1'b0;
        tick(); tick();
        vectors++; if (o_we !== 4'b0) begin miscompares++; $display("FAIL reset_we got %b want 0000", o_we); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", o_busy); end
        vectors++; if (o_waddr !== '0) begin miscompares++; $display("FAIL reset_waddr got %h want 0", o_waddr); end
        vectors++; if (o_wdata !== '0) begin miscompares++; $display("FAIL reset_wdata got %h want 0", o_wdata); end
        i_rst_n = 1'b1;
        tick();
        vectors++; if (o_ready !== 6'h3F) begin miscompares++; $display("FAIL reset_ready got %b want 111111", o_ready); end
        $display("[%0t] reset: released, ready=%b", $time, o_ready);
    endtask

    task automatic test_all_sources();
        for (int s = 0; s < NSRC; s++) drive(s, 5'(s + 1), 32'hA000_0000 + 32'(s));
        tick();
        i_valid = '0;
        repeat (LAT - 1) tick();
        vectors++; if (o_we !== 4'hF) begin miscompares++; $display("FAIL all_we_a got %b want 1111", o_we); end
        vectors++; if (o_waddr !== {5'd4, 5'd3, 5'd2, 5'd1}) begin miscompares++; $display("FAIL all_addr_a got %h want %h", o_waddr, {5'd4, 5'd3, 5'd2, 5'd1}); end
        vectors++; if (o_wdata !== {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000}) begin miscompares++; $display("FAIL all_data_a got %h", o_wdata); end
        $display("[%0t] all: cycle A we=%b addr=%h", $time, o_we, o_waddr);
        tick();
        vectors++; if (o_we !== 4'b0011) begin miscompares++; $display("FAIL all_we_b got %b want 0011", o_we); end
        vectors++; if (o_waddr[9:0] !== {5'd6, 5'd5}) begin miscompares++; $display("FAIL all_addr_b got %h want %h", o_waddr[9:0], {5'd6, 5'd5}); end
        vectors++; if (o_wdata[63:0] !== {32'hA000_0005, 32'hA000_0004}) begin miscompares++; $display("FAIL all_data_b got %h", o_wdata[63:0]); end
        vectors++; if (o_waddr[19:10] !== {5'd4, 5'd3}) begin miscompares++; $display("FAIL all_hold got %h want %h", o_waddr[19:10], {5'd4, 5'd3}); end
        $display("[%0t] all: cycle A+1 we=%b addr=%h", $time, o_we, o_waddr);
        tick();
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL all_idle got busy=%b want 0", o_busy); end
    endtask

    task automatic test_same_addr();
        drive(0, 5'd9, 32'h0000_0011);
        drive(1, 5'd9, 32'h0000_0022);
        tick();
        i_valid = '0;
        repeat (LAT - 1) tick();
        vectors++; if (o_we !== 4'b0001) begin miscompares++; $display("FAIL dup_we_a got %b want 0001", o_we); end
        vectors++; if (o_waddr[4:0] !== 5'd9 || o_wdata[31:0] !== 32'h11) begin miscompares++; $display("FAIL dup_port_a got %0d/%h want 9/11", o_waddr[4:0], o_wdata[31:0]); end
        $display("[%0t] dup: src0 we=%b data=%h", $time, o_we, o_wdata[31:0]);
        tick();
        vectors++; if (o_we !== 4'b0001) begin miscompares++; $display("FAIL dup_we_b got %b want 0001", o_we); end
        vectors++; if (o_waddr[4:0] !== 5'd9 || o_wdata[31:0] !== 32'h22) begin miscompares++; $display("FAIL dup_port_b got %0d/%h want 9/22", o_waddr[4:0], o_wdata[31:0]); end
        $display("[%0t] dup: src1 we=%b data=%h", $time, o_we, o_wdata[31:0]);
        tick();
        vectors++; if (o_we !== 4'b0) begin miscompares++; $display("FAIL dup_we_c got %b want 0000", o_we); end
    endtask

    task automatic test_single();
        drive(2, 5'd5, 32'hDEAD_BEEF);
        tick();
        i_valid = '0;
        repeat (LAT - 1) tick();
        vectors++; if (o_we !== 4'b0001) begin miscompares++; $display("FAIL single_we got %b want 0001", o_we); end
        vectors++; if (o_waddr[4:0] !== 5'd5) begin miscompares++; $display("FAIL single_addr got %0d want 5", o_waddr[4:0]); end
        vectors++; if (o_wdata[31:0] !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL single_data got %h want deadbeef", o_wdata[31:0]); end
        $display("[%0t] single: src2 -> port0 addr=%0d data=%h", $time, o_waddr[4:0], o_wdata[31:0]);
        tick();
        vectors++; if (o_we !== 4'b0 || o_busy !== 1'b0) begin miscompares++; $display("FAIL single_after got we=%b busy=%b want 0000/0", o_we, o_busy); end
        vectors++; if (o_waddr[4:0] !== 5'd5) begin miscompares++; $display("FAIL single_hold got %0d want 5", o_waddr[4:0]); end
    endtask

    task automatic test_zero_addr();
        drive(3, 5'd0, 32'h0000_0033);
        tick();
        i_valid = '0;
        for (int c = 0; c < 4; c++) begin
            vectors++; if (o_we !== 4'b0) begin miscompares++; $display("FAIL zero_we c%0d got %b want 0000", c, o_we); end
            tick();
        end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy got %b want 0", o_busy); end
        vectors++; if (o_ready !== 6'h3F) begin miscompares++; $display("FAIL zero_ready got %b want 111111", o_ready); end
        $display("[%0t] zero: src3 addr0 dropped, busy=%b", $time, o_busy);
    endtask

    task automatic test_backpressure();
        int acc_n;
        int wr_n;
        int low_at;
        bit saw5;
        acc_n = 0; wr_n = 0; low_at = -1; saw5 = 1'b0;
        for (int s = 1; s <= 4; s++) drive(s, 5'(s), 32'hB000_0000 + 32'(s));
        drive(5, 5'd7, 32'h5555_5555);
        drive(0, 5'd7, 32'h0000_0C00);
        for (int c = 0; c < 20; c++) begin
            bit acc0;
            acc0 = i_valid[0] && o_ready[0];
            tick();
            if (c == 0) i_valid[5:1] = '0;
            if (acc0) begin
                acc_n++;
                if (acc_n < 3) i_wdata[31:0] = 32'h0000_0C00 + 32'(acc_n);
                else i_valid[0] = 1'b0;
            end
            if (!o_ready[0] && low_at < 0) low_at = acc_n;
            for (int p = 0; p < 4; p++) begin
                if (o_we[p] && o_waddr[p*WIDTH +: WIDTH] == 5'd7) begin
                    if (o_wdata[p*32 +: 32] == 32'h5555_5555) saw5 = 1'b1;
                    else begin
                        vectors++;
                        if (o_wdata[p*32 +: 32] !== 32'h0000_0C00 + 32'(wr_n)) begin
                            miscompares++;
                            $display("FAIL bp_order got %h want %h", o_wdata[p*32 +: 32], 32'h0000_0C00 + 32'(wr_n));
                        end
                        $display("[%0t] bp: src0 write #%0d data=%h", $time, wr_n, o_wdata[p*32 +: 32]);
                        wr_n++;
                    end
                end
            end
        end
        vectors++; if (wr_n !== 3) begin miscompares++; $display("FAIL bp_count got %0d want 3", wr_n); end
        vectors++; if (saw5 !== 1'b1) begin miscompares++; $display("FAIL bp_src5 got %b want 1", saw5); end
`ifndef WB_BYPASS_EN
        vectors++; if (low_at !== 2) begin miscompares++; $display("FAIL bp_ready_fall got %0d want 2", low_at); end
`endif
        vectors++; if (o_busy !== 1'b0 || i_valid !== '0) begin miscompares++; $display("FAIL bp_drain got busy=%b valid=%b want 0/0", o_busy, i_valid); end
    endtask

    task automatic test_reset_mid_traffic();
        drive(0, 5'd10, 32'h0000_00A0);
        drive(1, 5'd11, 32'h0000_00A1);
        drive(2, 5'd12, 32'h0000_00A2);
        tick();
        i_valid = '0;
        i_rst_n = 1'b0;
        #1;
        vectors++; if (o_we !== 4'b0) begin miscompares++; $display("FAIL mid_we got %b want 0000", o_we); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy got %b want 0", o_busy); end
        tick(); tick();
        i_rst_n = 1'b1;
        tick();
        vectors++; if (o_ready !== 6'h3F) begin miscompares++; $display("FAIL mid_ready got %b want 111111", o_ready); end
        for (int c = 0; c < 4; c++) begin
            vectors++; if (o_we !== 4'b0) begin miscompares++; $display("FAIL mid_nowrite c%0d got %b want 0000", c, o_we); end
            tick();
        end
        vectors++; if (o_waddr !== '0) begin miscompares++; $display("FAIL mid_waddr got %h want 0", o_waddr); end
        $display("[%0t] mid-reset: queued entries discarded", $time);
    endtask

    initial begin
        test_reset();
        test_all_sources();
        test_same_addr();
        test_single();
        test_zero_addr();
        test_backpressure();
        test_reset_mid_traffic();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
